icache_mem_responder: RTL and testbench



---
 rtl/icache_mem_responder_pkg.sv | 32 +++
 rtl/icache_mem_responder_rr_arbiter.sv | 57 +++++
 rtl/icache_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_icache_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_mem_responder_pkg
//  Description : Shared types and constants for the I$ miss-port memory
//                responder: request struct, default latency, line width and
//                thread-slot sizing, plus a small index-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package icache_mem_responder_pkg;

   localparam int MAIN_MEMORY_LATENCY = 10;
   localparam int ICACHE_LINE_WIDTH   = 128;
   localparam int THR_PER_CORE        = 2;
   // One spare bit beyond $clog2(THR_PER_CORE) so that out-of-range thread
   // ids can actually be presented on the request bus and rejected.
   localparam int THR_PER_CORE_WIDTH  = 2;
   localparam int MEM_ADDR_W          = 32;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0]         addr;       // line address
      logic                          is_store;
      logic [ICACHE_LINE_WIDTH-1:0]  data;
      logic [THR_PER_CORE_WIDTH-1:0] thread_id;
   } memory_request_t;

   // Width of an index selecting one of n items (never zero).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_mem_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : icache_mem_responder_rr_arbiter
//  Description : Round-robin arbiter. Searches the request vector starting at
//                an internal pointer; after a grant the pointer moves to the
//                slot just past the winner.
//  Ports       : clock, reset     - clock, synchronous active-high reset
//                req_i  [N]       - request vector
//                gnt_o  [N]       - one-hot grant (combinational)
//                gnt_idx_o        - binary index of the granted slot
//                gnt_valid_o      - any grant this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module icache_mem_responder_rr_arbiter
   import icache_mem_responder_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] w_cand;

   always_comb begin
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      w_cand      = '0;
      for (int off = 0; off < N; off++) begin
         w_cand = IDX_W'((int'(ptr_q) + off) % N);
         if (!gnt_valid_o && req_i[w_cand]) begin
            gnt_valid_o     = 1'b1;
            gnt_o[w_cand]   = 1'b1;
            gnt_idx_o       = w_cand;
         end
      end
      ptr_d = gnt_valid_o ? IDX_W'((int'(gnt_idx_o) + 1) % N) : ptr_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/icache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_mem_responder
//  Description : Memory-side responder for the multithreaded I$ miss port.
//                One request slot per thread; each accepted line fill is
//                answered LATENCY cycles later (tagged with its thread id),
//                or flagged as a bus error for stores / out-of-range lines.
//                Holds the instruction line storage with a preload port.
//  Ports       : clock, reset       - clock, synchronous active-high reset
//                req_valid_miss     - miss request strobe
//                req_info_miss      - request (addr, is_store, data, thread_id)
//                rsp_valid_miss     - single-cycle response strobe
//                rsp_data_miss      - line data (zero on error)
//                rsp_bus_error      - response is an error
//                rsp_thread_id      - owner of the response
//                load_valid/addr/data - preload write port
//                protocol_error     - sticky, cleared only by reset
//  Revision    : 1.0  initial release
// ============================================================================
module icache_mem_responder
   import icache_mem_responder_pkg::*;
#(
   parameter int LATENCY     = MAIN_MEMORY_LATENCY,
   parameter int LINE_WIDTH  = ICACHE_LINE_WIDTH,
   parameter int NUM_LINES   = 1024,
   parameter int LINE_ADDR_W = $clog2(NUM_LINES),
   parameter int THREADS     = THR_PER_CORE
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req_valid_miss,
   input  memory_request_t               req_info_miss,
   output logic                          rsp_valid_miss,
   output logic [LINE_WIDTH-1:0]         rsp_data_miss,
   output logic                          rsp_bus_error,
   output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
   input  logic                          load_valid,
   input  logic [LINE_ADDR_W-1:0]        load_addr,
   input  logic [LINE_WIDTH-1:0]         load_data,
   output logic                          protocol_error
);

   localparam int IDX_W = idx_width(THREADS);

   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,
      SLOT_WAIT  = 2'd1,
      SLOT_READY = 2'd2
   } slot_state_t;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic [THREADS-1:0]     w_hit;
   logic [THREADS-1:0]     w_accept;
   logic [THREADS-1:0]     w_ready;
   logic [THREADS-1:0]     w_gnt;
   logic [IDX_W-1:0]       w_gnt_idx;
   logic                   w_gnt_valid;
   logic                   w_req_err;
   logic                   w_tid_bad;
   logic                   w_proto_set;
   logic [LINE_ADDR_W-1:0] w_slot_addr [THREADS];
   logic [THREADS-1:0]     w_slot_err;
   logic [LINE_ADDR_W-1:0] w_rd_addr;
   logic                   w_rd_err;
   logic                   w_unused;

   // Store payload is never written to storage; it is deliberately ignored.
   assign w_unused    = ^req_info_miss.data;

   assign w_req_err   = req_info_miss.is_store ||
                        (req_info_miss.addr >= MEM_ADDR_W'(NUM_LINES));
   assign w_tid_bad   = 32'(req_info_miss.thread_id) >= 32'(THREADS);
   // A hit that is not accepted means the slot is busy (WAIT, or READY but
   // losing arbitration this cycle).
   assign w_proto_set = req_valid_miss && (w_tid_bad || |(w_hit & ~w_accept));

   // ------------------------------------------------------------------
   // Per-thread slots
   // ------------------------------------------------------------------
   for (genvar i = 0; i < THREADS; i++) begin : g_slot
      slot_state_t            state_q;
      logic [7:0]             cnt_q;
      logic [LINE_ADDR_W-1:0] addr_q;
      logic                   err_q;

      assign w_hit[i]       = req_valid_miss &&
                              (req_info_miss.thread_id == THR_PER_CORE_WIDTH'(i));
      // A slot being granted this cycle is free again at the next edge, so
      // it may take a new request directly (READY -> WAIT).
      assign w_accept[i]    = w_hit[i] &&
                              ((state_q == SLOT_IDLE) ||
                               ((state_q == SLOT_READY) && w_gnt[i]));
      assign w_ready[i]     = (state_q == SLOT_READY);
      assign w_slot_addr[i] = addr_q;
      assign w_slot_err[i]  = err_q;

      // Countdown starts at LATENCY-2: one cycle is spent leaving WAIT once
      // the count hits zero and one in the response register, giving a
      // response exactly LATENCY edges after the accepting edge.
      always_ff @(posedge clock) begin
         if (reset) begin
            state_q <= SLOT_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
         end else if (w_accept[i]) begin
            state_q <= SLOT_WAIT;
            cnt_q   <= 8'(LATENCY - 2);
            addr_q  <= req_info_miss.addr[LINE_ADDR_W-1:0];
            err_q   <= w_req_err;
         end else begin
            case (state_q)
               SLOT_IDLE: begin
                  state_q <= SLOT_IDLE;
               end
               SLOT_WAIT: begin
                  if (cnt_q == 8'd0) begin
                     state_q <= SLOT_READY;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
               SLOT_READY: begin
                  if (w_gnt[i]) begin
                     state_q <= SLOT_IDLE;
                  end
               end
               default: begin
                  state_q <= SLOT_IDLE;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Response arbitration
   // ------------------------------------------------------------------
   icache_mem_responder_rr_arbiter #(
      .N     (THREADS),
      .IDX_W (IDX_W)
   ) u_arb (
      .clock       (clock),
      .reset       (reset),
      .req_i       (w_ready),
      .gnt_o       (w_gnt),
      .gnt_idx_o   (w_gnt_idx),
      .gnt_valid_o (w_gnt_valid)
   );

   assign w_rd_addr = w_slot_addr[w_gnt_idx];
   assign w_rd_err  = w_slot_err[w_gnt_idx];

   // ------------------------------------------------------------------
   // Line storage (not reset). The response register samples the array at
   // the same edge a preload writes it, so a same-cycle write is not seen.
   // ------------------------------------------------------------------
   logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

   always_ff @(posedge clock) begin
      if (load_valid) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   logic                          rsp_valid_q;
   logic [LINE_WIDTH-1:0]         rsp_data_q;
   logic                          rsp_err_q;
   logic [THR_PER_CORE_WIDTH-1:0] rsp_tid_q;
   logic                          proto_err_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tid_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         rsp_valid_q <= w_gnt_valid;
         proto_err_q <= proto_err_q | w_proto_set;
         if (w_gnt_valid) begin
            rsp_data_q <= w_rd_err ? '0 : mem_q[w_rd_addr];
            rsp_err_q  <= w_rd_err;
            rsp_tid_q  <= THR_PER_CORE_WIDTH'(w_gnt_idx);
         end
      end
   end

   assign rsp_valid_miss = rsp_valid_q;
   assign rsp_data_miss  = rsp_data_q;
   assign rsp_bus_error  = rsp_err_q;
   assign rsp_thread_id  = rsp_tid_q;
   assign protocol_error = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_mem_responder
//  Description : Directed self-checking bench for icache_mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_mem_responder;
   import icache_mem_responder_pkg::*;

   localparam logic [127:0] L3     = 128'h3333_0000_1111_2222_3333_4444_5555_0003;
   localparam logic [127:0] L4     = 128'h4444_0000_9999_8888_7777_6666_5555_0004;
   localparam logic [127:0] L5     = 128'hA5A5_0001_0002_0003_0004_0000_0000_0005;
   localparam logic [127:0] L7_OLD = 128'h0707_0000_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] L7_NEW = 128'h0707_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_0002;
   localparam logic [127:0] L1023  = 128'h03FF_1234_5678_9ABC_DEF0_0F0F_F0F0_03FF;

   logic            clock = 1'b0;
   logic            reset;
   logic            req_valid_miss;
   memory_request_t req_info_miss;
   logic            rsp_valid_miss;
   logic [127:0]    rsp_data_miss;
   logic            rsp_bus_error;
   logic [1:0]      rsp_thread_id;
   logic            load_valid;
   logic [9:0]      load_addr;
   logic [127:0]    load_data;
   logic            protocol_error;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      int           cyc;
      logic [1:0]   tid;
      logic [127:0] data;
      logic         err;
   } rsp_t;
   rsp_t q[$];

   icache_mem_responder #(
      .LATENCY     (10),
      .LINE_WIDTH  (128),
      .NUM_LINES   (1024),
      .LINE_ADDR_W (10),
      .THREADS     (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid_miss (req_valid_miss),
      .req_info_miss  (req_info_miss),
      .rsp_valid_miss (rsp_valid_miss),
      .rsp_data_miss  (rsp_data_miss),
      .rsp_bus_error  (rsp_bus_error),
      .rsp_thread_id  (rsp_thread_id),
      .load_valid     (load_valid),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .protocol_error (protocol_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Response log, sampled 1 time unit after each edge; cyc is the edge index.
   always @(posedge clock) begin
      #1;
      if (rsp_valid_miss === 1'b1)
         q.push_back('{cyc, rsp_thread_id, rsp_data_miss, rsp_bus_error});
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Request is sampled at the returned edge index t.
   task automatic issue(input logic [1:0] tid, input logic [31:0] addr,
                        input logic st, output int t);
      req_valid_miss          = 1'b1;
      req_info_miss.addr      = addr;
      req_info_miss.is_store  = st;
      req_info_miss.data      = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      req_info_miss.thread_id = tid;
      @(posedge clock);
      #1;
      t = cyc;
      req_valid_miss = 1'b0;
   endtask

   task automatic load(input logic [9:0] a, input logic [127:0] d);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      @(posedge clock);
      #1;
      load_valid = 1'b0;
   endtask

   task automatic test_reset;
      n_checks++; if (rsp_valid_miss !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", rsp_valid_miss); end
      n_checks++; if (rsp_data_miss !== 128'h0) begin n_errors++; $display("FAIL rst_data: got %h expected 0", rsp_data_miss); end
      n_checks++; if (rsp_bus_error !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", rsp_bus_error); end
      n_checks++; if (rsp_thread_id !== 2'd0) begin n_errors++; $display("FAIL rst_tid: got %0d expected 0", rsp_thread_id); end
      n_checks++; if (protocol_error !== 1'b0) begin n_errors++; $display("FAIL rst_proto: got %b expected 0", protocol_error); end
   endtask

   task automatic test_latency;
      int t;
      q.delete();
      issue(2'd0, 32'd5, 1'b0, t);
      step(14);
      n_checks++; if (q.size() !== 1) begin n_errors++; $display("FAIL lat_count: got %0d expected 1", q.size()); end
      n_checks++; if (q[0].cyc !== t + 10) begin n_errors++; $display("FAIL lat_cycle: got %0d expected %0d", q[0].cyc, t + 10); end
      n_checks++; if (q[0].tid !== 2'd0) begin n_errors++; $display("FAIL lat_tid: got %0d expected 0", q[0].tid); end
      n_checks++; if (q[0].data !== L5) begin n_errors++; $display("FAIL lat_data: got %h expected %h", q[0].data, L5); end
      n_checks++; if (q[0].err !== 1'b0) begin n_errors++; $display("FAIL lat_err: got %b expected 0", q[0].err); end
   endtask

   task automatic test_back_to_back;
      int t0, t1;
      q.delete();
      issue(2'd0, 32'd3, 1'b0, t0);
      issue(2'd1, 32'd4, 1'b0, t1);
      step(15);
      n_checks++; if (q.size() !== 2) begin n_errors++; $display("FAIL b2b_count: got %0d expected 2", q.size()); end
      n_checks++; if (q[0].cyc !== t0 + 10) begin n_errors++; $display("FAIL b2b_cyc0: got %0d expected %0d", q[0].cyc, t0 + 10); end
      n_checks++; if (q[0].tid !== 2'd0 || q[0].data !== L3) begin n_errors++; $display("FAIL b2b_rsp0: got tid=%0d data=%h expected tid=0 data=%h", q[0].tid, q[0].data, L3); end
      n_checks++; if (q[1].cyc !== t0 + 11) begin n_errors++; $display("FAIL b2b_cyc1: got %0d expected %0d", q[1].cyc, t0 + 11); end
      n_checks++; if (q[1].tid !== 2'd1 || q[1].data !== L4) begin n_errors++; $display("FAIL b2b_rsp1: got tid=%0d data=%h expected tid=1 data=%h", q[1].tid, q[1].data, L4); end
   endtask

   task automatic test_bus_error;
      int t;
      q.delete();
      issue(2'd1, 32'd1024, 1'b0, t);
      step(14);
      n_checks++; if (q.size() !== 1) begin n_errors++; $display("FAIL oor_count: got %0d expected 1", q.size()); end
      n_checks++; if (q[0].cyc !== t + 10 || q[0].tid !== 2'd1) begin n_errors++; $display("FAIL oor_when: got cyc=%0d tid=%0d expected cyc=%0d tid=1", q[0].cyc, q[0].tid, t + 10); end
      n_checks++; if (q[0].err !== 1'b1 || q[0].data !== 128'h0) begin n_errors++; $display("FAIL oor_err: got err=%b data=%h expected err=1 data=0", q[0].err, q[0].data); end
      q.delete();
      issue(2'd1, 32'd3, 1'b1, t);
      step(14);
      n_checks++; if (q.size() !== 1) begin n_errors++; $display("FAIL st_count: got %0d expected 1", q.size()); end
      n_checks++; if (q[0].err !== 1'b1 || q[0].data !== 128'h0) begin n_errors++; $display("FAIL st_err: got err=%b data=%h expected err=1 data=0", q[0].err, q[0].data); end
      q.delete();
      issue(2'd1, 32'd1023, 1'b0, t);
      step(14);
      n_checks++; if (q[0].err !== 1'b0 || q[0].data !== L1023) begin n_errors++; $display("FAIL last_line: got err=%b data=%h expected err=0 data=%h", q[0].err, q[0].data, L1023); end
      q.delete();
      issue(2'd0, 32'd3, 1'b0, t);
      step(14);
      n_checks++; if (q[0].data !== L3) begin n_errors++; $display("FAIL st_nowrite: got %h expected %h", q[0].data, L3); end
      n_checks++; if (protocol_error !== 1'b0) begin n_errors++; $display("FAIL err_proto: got %b expected 0", protocol_error); end
   endtask

   task automatic test_same_cycle_accept;
      int t, t2;
      q.delete();
      issue(2'd0, 32'd5, 1'b0, t);
      step(9);
      issue(2'd0, 32'd3, 1'b0, t2);  // sampled in the grant cycle of the first
      step(15);
      n_checks++; if (t2 !== t + 10) begin n_errors++; $display("FAIL sca_setup: got %0d expected %0d", t2, t + 10); end
      n_checks++; if (protocol_error !== 1'b0) begin n_errors++; $display("FAIL sca_proto: got %b expected 0", protocol_error); end
      n_checks++; if (q.size() !== 2) begin n_errors++; $display("FAIL sca_count: got %0d expected 2", q.size()); end
      n_checks++; if (q[0].cyc !== t + 10 || q[0].data !== L5) begin n_errors++; $display("FAIL sca_rsp0: got cyc=%0d data=%h expected cyc=%0d data=%h", q[0].cyc, q[0].data, t + 10, L5); end
      n_checks++; if (q[1].cyc !== t + 20 || q[1].data !== L3) begin n_errors++; $display("FAIL sca_rsp1: got cyc=%0d data=%h expected cyc=%0d data=%h", q[1].cyc, q[1].data, t + 20, L3); end
   endtask

   task automatic test_preload_collision;
      int t;
      q.delete();
      issue(2'd0, 32'd7, 1'b0, t);
      step(9);
      load(10'd7, L7_NEW);           // write lands on the response edge
      step(12);
      n_checks++; if (q.size() !== 1 || q[0].cyc !== t + 10) begin n_errors++; $display("FAIL col_when: got n=%0d cyc=%0d expected n=1 cyc=%0d", q.size(), q[0].cyc, t + 10); end
      n_checks++; if (q[0].data !== L7_OLD) begin n_errors++; $display("FAIL col_old: got %h expected %h", q[0].data, L7_OLD); end
      q.delete();
      issue(2'd0, 32'd7, 1'b0, t);
      step(14);
      n_checks++; if (q[0].data !== L7_NEW) begin n_errors++; $display("FAIL col_new: got %h expected %h", q[0].data, L7_NEW); end
   endtask

   task automatic test_protocol_error;
      int t, t2;
      q.delete();
      issue(2'd0, 32'd4, 1'b0, t);
      step(2);
      issue(2'd0, 32'd3, 1'b0, t2);
      n_checks++; if (protocol_error !== 1'b1) begin n_errors++; $display("FAIL pe_set: got %b expected 1", protocol_error); end
      step(25);
      n_checks++; if (q.size() !== 1) begin n_errors++; $display("FAIL pe_count: got %0d expected 1", q.size()); end
      n_checks++; if (q[0].cyc !== t + 10 || q[0].data !== L4) begin n_errors++; $display("FAIL pe_rsp: got cyc=%0d data=%h expected cyc=%0d data=%h", q[0].cyc, q[0].data, t + 10, L4); end
      n_checks++; if (protocol_error !== 1'b1) begin n_errors++; $display("FAIL pe_sticky: got %b expected 1", protocol_error); end
   endtask

   task automatic test_reset_outstanding;
      int t, t1;
      q.delete();
      issue(2'd0, 32'd5, 1'b0, t);
      issue(2'd1, 32'd4, 1'b0, t1);
      step(3);
      reset = 1'b1;                   // sampled at edge t+5
      step(1);
      reset = 1'b0;
      step(20);
      n_checks++; if (q.size() !== 0) begin n_errors++; $display("FAIL ro_silent: got %0d responses expected 0", q.size()); end
      n_checks++; if (protocol_error !== 1'b0) begin n_errors++; $display("FAIL ro_proto: got %b expected 0", protocol_error); end
      issue(2'd0, 32'd5, 1'b0, t);
      step(14);
      n_checks++; if (q.size() !== 1 || q[0].data !== L5 || q[0].cyc !== t + 10) begin n_errors++; $display("FAIL ro_after: got n=%0d cyc=%0d data=%h expected n=1 cyc=%0d data=%h", q.size(), q[0].cyc, q[0].data, t + 10, L5); end
   endtask

   task automatic test_bad_thread;
      int t;
      q.delete();
      issue(2'd2, 32'd5, 1'b0, t);
      n_checks++; if (protocol_error !== 1'b1) begin n_errors++; $display("FAIL bt_proto: got %b expected 1", protocol_error); end
      issue(2'd3, 32'd4, 1'b0, t);
      step(15);
      n_checks++; if (q.size() !== 0) begin n_errors++; $display("FAIL bt_dropped: got %0d responses expected 0", q.size()); end
   endtask

   initial begin
      reset          = 1'b1;
      req_valid_miss = 1'b0;
      req_info_miss  = '0;
      load_valid     = 1'b0;
      load_addr      = '0;
      load_data      = '0;
      step(3);
      test_reset();
      reset = 1'b0;
      step(1);
      load(10'd3, L3);
      load(10'd4, L4);
      load(10'd5, L5);
      load(10'd7, L7_OLD);
      load(10'd1023, L1023);
      test_latency();
      test_back_to_back();
      test_bus_error();
      test_same_cycle_accept();
      test_preload_collision();
      test_protocol_error();
      test_reset_outstanding();
      test_bad_thread();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
